// File: rtl/video_timing_generate.sv
// Runtime-programmable video timing generator: syncs, data enable, pixel coordinates and frame/line strobes.
// Define VTG_TPG_EN to add an 8-bar colour test pattern on pix_data; otherwise pix_data is tied to 0.
module video_timing_generate #(
    parameter int unsigned CNT_W     = 13,
    parameter bit          SYNC_POL  = 1'b1,
    parameter bit          ABORT_DIS = 1'b0,
    parameter int unsigned BPC       = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [CNT_W-1:0]   cfg_hact,
    input  logic [CNT_W-1:0]   cfg_hfp,
    input  logic [CNT_W-1:0]   cfg_hsw,
    input  logic [CNT_W-1:0]   cfg_hbp,
    input  logic [CNT_W-1:0]   cfg_vact,
    input  logic [CNT_W-1:0]   cfg_vfp,
    input  logic [CNT_W-1:0]   cfg_vsw,
    input  logic [CNT_W-1:0]   cfg_vbp,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [CNT_W-1:0]   x,
    output logic [CNT_W-1:0]   y,
    output logic               frame_start,
    output logic               line_start,
    output logic               busy,
    output logic               cfg_err,
    output logic [3*BPC-1:0]   pix_data
);
    localparam int unsigned      SUM_W   = CNT_W + 2;
    localparam logic [SUM_W-1:0] TOT_MAX = {2'b00, {CNT_W{1'b1}}};
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] hcnt, vcnt;
    logic [CNT_W-1:0] sh_hsw, sh_hast, sh_haen, sh_htot;
    logic [CNT_W-1:0] sh_vsw, sh_vast, sh_vaen, sh_vtot;

    logic [CNT_W-1:0] hast_c, haen_c, vast_c, vaen_c;
    logic [SUM_W-1:0] htot_c, vtot_c;
    logic             cfg_ok_c;
    logic             load_c, clr_c, adv_c, err_set_c;
    logic             h_last_c, v_last_c, frame_last_c;
    logic             run_c, hs_c, vs_c, h_act_c, v_act_c, de_c, h_zero_c, v_zero_c;

    // Candidate geometry; totals are widened so an oversize sum cannot wrap into range
    always_comb begin
        hast_c   = cfg_hsw + cfg_hbp;
        haen_c   = hast_c + cfg_hact;
        vast_c   = cfg_vsw + cfg_vbp;
        vaen_c   = vast_c + cfg_vact;
        htot_c   = SUM_W'(cfg_hsw) + SUM_W'(cfg_hbp) + SUM_W'(cfg_hact) + SUM_W'(cfg_hfp);
        vtot_c   = SUM_W'(cfg_vsw) + SUM_W'(cfg_vbp) + SUM_W'(cfg_vact) + SUM_W'(cfg_vfp);
        cfg_ok_c = (cfg_hact != '0) && (cfg_hsw != '0) && (cfg_vact != '0) && (cfg_vsw != '0)
                   && (htot_c <= TOT_MAX) && (vtot_c <= TOT_MAX);
    end

    always_comb begin
        run_c        = (state != IDLE);
        h_zero_c     = (hcnt == '0);
        v_zero_c     = (vcnt == '0);
        h_last_c     = (hcnt == sh_htot - ONE);
        v_last_c     = (vcnt == sh_vtot - ONE);
        frame_last_c = h_last_c && v_last_c;
        hs_c         = run_c && (hcnt < sh_hsw);
        vs_c         = run_c && (vcnt < sh_vsw);
        h_act_c      = (hcnt >= sh_hast) && (hcnt < sh_haen);
        v_act_c      = (vcnt >= sh_vast) && (vcnt < sh_vaen);
        de_c         = run_c && h_act_c && v_act_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state; a frame ending with enable low returns to IDLE, otherwise the shadow reload is attempted
    always_comb begin
        state_nxt = state;
        load_c    = 1'b0;
        clr_c     = 1'b0;
        adv_c     = 1'b0;
        err_set_c = 1'b0;
        case (state)
            IDLE: begin
                if (enable) begin
                    if (cfg_ok_c) begin
                        load_c    = 1'b1;
                        clr_c     = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        err_set_c = 1'b1;
                    end
                end
            end
            RUN, DRAIN: begin
                if (!enable && ABORT_DIS) begin
                    clr_c     = 1'b1;
                    state_nxt = IDLE;
                end else if (frame_last_c && !enable) begin
                    clr_c     = 1'b1;
                    state_nxt = IDLE;
                end else begin
                    adv_c     = 1'b1;
                    state_nxt = enable ? RUN : DRAIN;
                    if (frame_last_c) begin
                        load_c    = cfg_ok_c;
                        err_set_c = !cfg_ok_c;
                    end
                end
            end
            default: begin
                clr_c     = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_hsw  <= '0;
            sh_hast <= '0;
            sh_haen <= '0;
            sh_htot <= '0;
            sh_vsw  <= '0;
            sh_vast <= '0;
            sh_vaen <= '0;
            sh_vtot <= '0;
            cfg_err <= 1'b0;
        end else begin
            if (load_c) begin
                sh_hsw  <= cfg_hsw;
                sh_hast <= hast_c;
                sh_haen <= haen_c;
                sh_htot <= CNT_W'(htot_c);
                sh_vsw  <= cfg_vsw;
                sh_vast <= vast_c;
                sh_vaen <= vaen_c;
                sh_vtot <= CNT_W'(vtot_c);
            end
            if (err_set_c)   cfg_err <= 1'b1;
            else if (load_c) cfg_err <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (clr_c) begin
            hcnt <= '0;
            vcnt <= '0;
        end else if (adv_c) begin
            if (h_last_c) begin
                hcnt <= '0;
                vcnt <= v_last_c ? '0 : vcnt + ONE;
            end else begin
                hcnt <= hcnt + ONE;
            end
        end
    end

    // Output stage: one clock behind the counters; coordinates hold outside the active area
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            frame_start <= 1'b0;
            line_start  <= 1'b0;
            busy        <= 1'b0;
        end else begin
            hsync       <= hs_c ? SYNC_POL : ~SYNC_POL;
            vsync       <= vs_c ? SYNC_POL : ~SYNC_POL;
            de          <= de_c;
            frame_start <= run_c && h_zero_c && v_zero_c;
            line_start  <= run_c && h_zero_c;
            busy        <= run_c;
            if (!run_c)                  x <= '0;
            else if (de_c)               x <= hcnt - sh_hast;
            else if (h_zero_c)           x <= '0;
            if (!run_c)                  y <= '0;
            else if (de_c)               y <= vcnt - sh_vast;
            else if (h_zero_c && v_zero_c) y <= '0;
        end
    end

`ifdef VTG_TPG_EN
    logic [CNT_W-1:0] sh_bw, bar_pos, bar_pos_c, hact_div8_c;
    logic [2:0]       bar_idx, bar_idx_c;
    logic             bar_first_c;

    // Bar position tracked incrementally; the last bar absorbs the remainder of the line
    always_comb begin
        hact_div8_c = cfg_hact >> 3;
        bar_first_c = (hcnt == sh_hast);
        bar_idx_c   = bar_first_c ? 3'd0 : bar_idx;
        bar_pos_c   = bar_first_c ? '0 : bar_pos;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_bw    <= ONE;
            bar_pos  <= '0;
            bar_idx  <= 3'd0;
            pix_data <= '0;
        end else begin
            if (load_c) sh_bw <= (hact_div8_c == '0) ? ONE : hact_div8_c;
            if (de_c) begin
                if ((bar_idx_c != 3'd7) && (bar_pos_c + ONE == sh_bw)) begin
                    bar_idx <= bar_idx_c + 3'd1;
                    bar_pos <= '0;
                end else begin
                    bar_idx <= bar_idx_c;
                    bar_pos <= (bar_idx_c == 3'd7) ? bar_pos_c : bar_pos_c + ONE;
                end
            end
            pix_data <= de_c ? {{BPC{~bar_idx_c[1]}}, {BPC{~bar_idx_c[2]}}, {BPC{~bar_idx_c[0]}}} : '0;
        end
    end
`else
    assign pix_data = '0;
`endif

endmodule

// File: tb/tb_video_timing_generate.sv
// Randomised self-checking bench for video_timing_generate against a frame-position reference model.
`timescale 1ns/1ps
module tb_video_timing_generate;
    localparam int unsigned CNT_W     = 13;
    localparam bit          SYNC_POL  = 1'b1;
    localparam bit          ABORT_DIS = 1'b0;
    localparam int unsigned BPC       = 8;
    localparam int          TOT_MAX   = (1 << CNT_W) - 1;

    logic             clk    = 1'b0;
    logic             rst_n  = 1'b0;
    logic             enable = 1'b0;
    logic [CNT_W-1:0] cfg_hact = '0, cfg_hfp = '0, cfg_hsw = '0, cfg_hbp = '0;
    logic [CNT_W-1:0] cfg_vact = '0, cfg_vfp = '0, cfg_vsw = '0, cfg_vbp = '0;
    logic             hsync, vsync, de, frame_start, line_start, busy, cfg_err;
    logic [CNT_W-1:0] x, y;
    logic [3*BPC-1:0] pix_data;

    int n_checks = 0;
    int n_errors = 0;

    // reference model: active flag, linear position within the frame, latched geometry
    int m_act, m_pos, m_err;
    int s_hact, s_hfp, s_hsw, s_hbp, s_vact, s_vfp, s_vsw, s_vbp;
    int e_hs, e_vs, e_de, e_x, e_y, e_fs, e_ls, e_busy, e_pix;

    int cyc = 0, last_fs = 0, last_period = 0;
    int hs_acc = 0, de_acc = 0, hs_frame = 0, de_frame = 0;

    always #5 clk = ~clk;

    video_timing_generate #(
        .CNT_W(CNT_W), .SYNC_POL(SYNC_POL), .ABORT_DIS(ABORT_DIS), .BPC(BPC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable),
        .cfg_hact(cfg_hact), .cfg_hfp(cfg_hfp), .cfg_hsw(cfg_hsw), .cfg_hbp(cfg_hbp),
        .cfg_vact(cfg_vact), .cfg_vfp(cfg_vfp), .cfg_vsw(cfg_vsw), .cfg_vbp(cfg_vbp),
        .hsync(hsync), .vsync(vsync), .de(de), .x(x), .y(y),
        .frame_start(frame_start), .line_start(line_start), .busy(busy),
        .cfg_err(cfg_err), .pix_data(pix_data)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

`ifdef VTG_TPG_EN
    function automatic int bar_rgb(input int idx);
        case (idx)
            0:       return 32'hFFFFFF;
            1:       return 32'hFFFF00;
            2:       return 32'h00FFFF;
            3:       return 32'h00FF00;
            4:       return 32'hFF00FF;
            5:       return 32'hFF0000;
            6:       return 32'h0000FF;
            default: return 32'h000000;
        endcase
    endfunction
`endif

    function automatic bit cfg_valid();
        int ht, vt;
        ht = int'(cfg_hact) + int'(cfg_hfp) + int'(cfg_hsw) + int'(cfg_hbp);
        vt = int'(cfg_vact) + int'(cfg_vfp) + int'(cfg_vsw) + int'(cfg_vbp);
        return (cfg_hact != 0) && (cfg_hsw != 0) && (cfg_vact != 0) && (cfg_vsw != 0)
               && (ht <= TOT_MAX) && (vt <= TOT_MAX);
    endfunction

    task automatic idle_outputs();
        e_hs = int'(!SYNC_POL); e_vs = int'(!SYNC_POL);
        e_de = 0; e_x = 0; e_y = 0; e_fs = 0; e_ls = 0; e_busy = 0; e_pix = 0;
    endtask

    task automatic model_reset();
        m_act = 0; m_pos = 0; m_err = 0;
        idle_outputs();
    endtask

    task automatic model_load();
        s_hact = int'(cfg_hact); s_hfp = int'(cfg_hfp); s_hsw = int'(cfg_hsw); s_hbp = int'(cfg_hbp);
        s_vact = int'(cfg_vact); s_vfp = int'(cfg_vfp); s_vsw = int'(cfg_vsw); s_vbp = int'(cfg_vbp);
        m_err = 0;
    endtask

    // one clock edge: outputs reflect the position before the edge, then the position advances
    task automatic model_step();
        int ht, vt, h, v, ha, va;
        if (!rst_n) begin
            model_reset();
            return;
        end
        if (m_act != 0) begin
            ht = s_hact + s_hfp + s_hsw + s_hbp;
            vt = s_vact + s_vfp + s_vsw + s_vbp;
            h  = m_pos % ht;
            v  = m_pos / ht;
            ha = s_hsw + s_hbp;
            va = s_vsw + s_vbp;
            e_hs   = (h < s_hsw) ? int'(SYNC_POL) : int'(!SYNC_POL);
            e_vs   = (v < s_vsw) ? int'(SYNC_POL) : int'(!SYNC_POL);
            e_de   = (h >= ha && h < ha + s_hact && v >= va && v < va + s_vact) ? 1 : 0;
            if (e_de != 0)      e_x = h - ha;
            else if (h == 0)    e_x = 0;
            if (e_de != 0)      e_y = v - va;
            else if (m_pos == 0) e_y = 0;
            e_fs   = (m_pos == 0) ? 1 : 0;
            e_ls   = (h == 0) ? 1 : 0;
            e_busy = 1;
            e_pix  = 0;
`ifdef VTG_TPG_EN
            if (e_de != 0) begin
                int bw, idx;
                bw  = ((s_hact >> 3) < 1) ? 1 : (s_hact >> 3);
                idx = (h - ha) / bw;
                if (idx > 7) idx = 7;
                e_pix = bar_rgb(idx);
            end
`endif
            if (!enable && ABORT_DIS) begin
                m_act = 0; m_pos = 0;
            end else if (m_pos == ht * vt - 1) begin
                if (enable) begin
                    m_pos = 0;
                    if (cfg_valid()) model_load();
                    else             m_err = 1;
                end else begin
                    m_act = 0; m_pos = 0;
                end
            end else begin
                m_pos++;
            end
        end else begin
            idle_outputs();
            if (enable) begin
                if (cfg_valid()) begin
                    model_load();
                    m_pos = 0;
                    m_act = 1;
                end else begin
                    m_err = 1;
                end
            end
        end
    endtask

    task automatic compare_all();
        check_val("hsync",       32'(hsync),       32'(e_hs));
        check_val("vsync",       32'(vsync),       32'(e_vs));
        check_val("de",          32'(de),          32'(e_de));
        check_val("x",           32'(x),           32'(e_x));
        check_val("y",           32'(y),           32'(e_y));
        check_val("frame_start", 32'(frame_start), 32'(e_fs));
        check_val("line_start",  32'(line_start),  32'(e_ls));
        check_val("busy",        32'(busy),        32'(e_busy));
        check_val("cfg_err",     32'(cfg_err),     32'(m_err));
        check_val("pix_data",    32'(pix_data),    32'(e_pix));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        cyc++;
        if (frame_start) begin
            last_period = cyc - last_fs;
            last_fs     = cyc;
            hs_frame    = hs_acc;
            de_frame    = de_acc;
            hs_acc      = 0;
            de_acc      = 0;
        end
        if (hsync == SYNC_POL) hs_acc++;
        if (de)                de_acc++;
    endtask

    task automatic wait_fs(input string tag);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 2000 && !seen; i++) begin
            tick();
            seen = frame_start;
        end
        check_val(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 2000 && busy; i++) tick();
        check_val(tag, 32'(busy), 32'd0);
    endtask

    task automatic set_cfg(input int ha, input int hf, input int hs, input int hb,
                           input int va, input int vf, input int vs, input int vb);
        cfg_hact = CNT_W'(ha); cfg_hfp = CNT_W'(hf); cfg_hsw = CNT_W'(hs); cfg_hbp = CNT_W'(hb);
        cfg_vact = CNT_W'(va); cfg_vfp = CNT_W'(vf); cfg_vsw = CNT_W'(vs); cfg_vbp = CNT_W'(vb);
    endtask

    task automatic rand_cfg();
        set_cfg($urandom_range(1, 20), $urandom_range(0, 3),
                ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 3), $urandom_range(0, 3),
                $urandom_range(1, 5), $urandom_range(0, 2),
                ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, 2), $urandom_range(0, 2));
    endtask

    initial begin
        model_reset();
        set_cfg(8, 2, 2, 2, 4, 1, 1, 1);
        #3;
        compare_all();
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // nominal geometry: 14 x 7
        enable = 1'b1;
        wait_fs("t1_fs_first");
        wait_fs("t1_fs_second");
        check_val("t1_period", 32'(last_period), 32'd98);
        check_val("t1_hsync_clks", 32'(hs_frame), 32'd14);
        check_val("t1_de_clks", 32'(de_frame), 32'd32);

        // mid-frame cfg change only takes effect at the next frame
        for (int i = 0; i < 20; i++) tick();
        cfg_hact = CNT_W'(4);
        wait_fs("t2_fs_a");
        check_val("t2_period_old", 32'(last_period), 32'd98);
        check_val("t2_de_old", 32'(de_frame), 32'd32);
        wait_fs("t2_fs_b");
        check_val("t2_period_new", 32'(last_period), 32'd70);
        check_val("t2_de_new", 32'(de_frame), 32'd16);

        // graceful stop mid-frame
        cfg_hact = CNT_W'(8);
        wait_fs("t4_fs");
        for (int i = 0; i < 42; i++) tick();
        enable = 1'b0;
        wait_idle("t4_idle");
        check_val("t4_drain_len", 32'(cyc - last_fs), 32'd98);
        check_val("t4_hsync_off", 32'(hsync), 32'(!SYNC_POL));

        // rejected load while idle, then recovery
        cfg_hsw = '0;
        enable  = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check_val("t3_busy", 32'(busy), 32'd0);
        check_val("t3_err", 32'(cfg_err), 32'd1);
        cfg_hsw = CNT_W'(2);
        tick();
        check_val("t3_err_clr", 32'(cfg_err), 32'd0);
        tick();
        check_val("t3_busy_run", 32'(busy), 32'd1);

        // oversize totals are rejected
        enable = 1'b0;
        wait_idle("ovf_idle");
        set_cfg(8190, 0, 1, 1, 4, 1, 1, 1);
        enable = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        check_val("ovf_h_err", 32'(cfg_err), 32'd1);
        check_val("ovf_h_busy", 32'(busy), 32'd0);
        set_cfg(8, 2, 2, 2, 8190, 0, 1, 1);
        for (int i = 0; i < 3; i++) tick();
        check_val("ovf_v_err", 32'(cfg_err), 32'd1);
        set_cfg(8, 2, 2, 2, 4, 1, 1, 1);
        for (int i = 0; i < 3; i++) tick();

        // randomised geometry, cfg churn and enable toggling
        for (int i = 0; i < 12000; i++) begin
            if ($urandom_range(0, 19) == 0)  rand_cfg();
            if ($urandom_range(0, 299) == 0) enable = ~enable;
            tick();
        end

        // asynchronous reset in the active area
        set_cfg(8, 2, 2, 2, 4, 1, 1, 1);
        enable = 1'b1;
        for (int i = 0; i < 600 && !de; i++) tick();
        check_val("rst_de_seen", 32'(de), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check_val("rst_de", 32'(de), 32'd0);
        check_val("rst_hsync", 32'(hsync), 32'(!SYNC_POL));
        check_val("rst_vsync", 32'(vsync), 32'(!SYNC_POL));
        check_val("rst_x", 32'(x), 32'd0);
        check_val("rst_y", 32'(y), 32'd0);
        check_val("rst_busy", 32'(busy), 32'd0);
        model_reset();
        for (int i = 0; i < 3; i++) tick();
        rst_n = 1'b1;
        wait_fs("rst_restart_fs");
        wait_fs("rst_restart_fs2");
        check_val("rst_restart_period", 32'(last_period), 32'd98);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
